// File: rtl/id_hazard_scoreboard_if.sv
// id_hazard_scoreboard_if: decode-stage bus carrying source/dest indices, regfile data,
// forward sources and the resolved operands/stall back to the pipeline.
interface id_hazard_scoreboard_if #(
   parameter int IDX_W   = 5,
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 3,
   parameter int LAT_W   = 3,
   parameter int SEL_W   = 2
);
   logic                     id_valid;
   logic [IDX_W-1:0]         id_rs1_idx;
   logic [IDX_W-1:0]         id_rs2_idx;
   logic                     id_rs1_used;
   logic                     id_rs2_used;
   logic [IDX_W-1:0]         id_rd_idx;
   logic                     id_reg_wr;
   logic [LAT_W-1:0]         id_lat;
   logic                     ex_ready;
   logic                     flush;
   logic [XLEN-1:0]          rf_rs1_data;
   logic [XLEN-1:0]          rf_rs2_data;
   logic [NUM_FWD*IDX_W-1:0] fwd_rd;
   logic [NUM_FWD-1:0]       fwd_wr;
   logic [NUM_FWD*XLEN-1:0]  fwd_data;
   logic [XLEN-1:0]          rs1_val;
   logic [XLEN-1:0]          rs2_val;
   logic [SEL_W-1:0]         rs1_sel;
   logic [SEL_W-1:0]         rs2_sel;
   logic                     stall;
   logic                     id_fire;
   logic [31:0]              stall_cnt;

   modport master (
      output id_valid, id_rs1_idx, id_rs2_idx, id_rs1_used, id_rs2_used, id_rd_idx,
             id_reg_wr, id_lat, ex_ready, flush, rf_rs1_data, rf_rs2_data,
             fwd_rd, fwd_wr, fwd_data,
      input  rs1_val, rs2_val, rs1_sel, rs2_sel, stall, id_fire, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs1_idx, id_rs2_idx, id_rs1_used, id_rs2_used, id_rd_idx,
             id_reg_wr, id_lat, ex_ready, flush, rf_rs1_data, rf_rs2_data,
             fwd_rd, fwd_wr, fwd_data,
      output rs1_val, rs2_val, rs1_sel, rs2_sel, stall, id_fire, stall_cnt
   );
endinterface

// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard: per-register result-latency countdowns raising load/mul stalls,
// youngest-first operand bypass from ordered forward sources, and a saturating stall counter.
module id_hazard_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int IDX_W    = 5,
   parameter int XLEN     = 32,
   parameter int NUM_FWD  = 3,
   parameter int LAT_W    = 3,
   parameter int SEL_W    = 2
) (
   input logic                   clk,
   input logic                   rst,
   id_hazard_scoreboard_if.slave bus
);
   logic [LAT_W-1:0] r_cnt [NUM_REGS];
   logic [31:0]      r_stall_cnt;
   logic             w_haz1;
   logic             w_haz2;
   logic             w_stall;
   logic             w_fire;
   logic             w_load;
   logic [SEL_W-1:0] w_sel1;
   logic [SEL_W-1:0] w_sel2;
   logic [XLEN-1:0]  w_val1;
   logic [XLEN-1:0]  w_val2;

   // Hazards look only at counts left by older instructions, never the one issuing now.
   assign w_haz1  = bus.id_rs1_used && bus.id_rs1_idx != '0 && r_cnt[bus.id_rs1_idx] != '0;
   assign w_haz2  = bus.id_rs2_used && bus.id_rs2_idx != '0 && r_cnt[bus.id_rs2_idx] != '0;
   assign w_stall = bus.id_valid && !bus.flush && (w_haz1 || w_haz2);
   assign w_fire  = bus.id_valid && !w_stall && !bus.flush && bus.ex_ready;
   assign w_load  = w_fire && bus.id_reg_wr && bus.id_rd_idx != '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_cnt[0] <= '0;
         if (bus.ex_ready)
            for (int r = 1; r < NUM_REGS; r++)
               r_cnt[r] <= (w_load && bus.id_rd_idx == IDX_W'(r)) ? bus.id_lat :
                           (r_cnt[r] != '0) ? r_cnt[r] - LAT_W'(1) : '0;
         if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   // Scan oldest to youngest so the youngest matching source is the one left standing.
   always_comb begin
      w_sel1 = '0;
      w_sel2 = '0;
      w_val1 = bus.rf_rs1_data;
      w_val2 = bus.rf_rs2_data;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if (bus.id_rs1_used && bus.id_rs1_idx != '0 && bus.fwd_wr[k] &&
             bus.fwd_rd[k*IDX_W +: IDX_W] == bus.id_rs1_idx) begin
            w_sel1 = SEL_W'(k + 1);
            w_val1 = bus.fwd_data[k*XLEN +: XLEN];
         end
         if (bus.id_rs2_used && bus.id_rs2_idx != '0 && bus.fwd_wr[k] &&
             bus.fwd_rd[k*IDX_W +: IDX_W] == bus.id_rs2_idx) begin
            w_sel2 = SEL_W'(k + 1);
            w_val2 = bus.fwd_data[k*XLEN +: XLEN];
         end
      end
   end

   assign bus.stall     = w_stall;
   assign bus.id_fire   = w_fire;
   assign bus.rs1_sel   = w_sel1;
   assign bus.rs2_sel   = w_sel2;
   assign bus.rs1_val   = w_val1;
   assign bus.rs2_val   = w_val2;
   assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb_id_hazard_scoreboard: scenario tasks push expected {stall, fire, sels, vals} when driving
// a decode slot and pop/compare them at the following negedge.
module tb_id_hazard_scoreboard;
   localparam logic [31:0] R1 = 32'hAAAA_0001;
   localparam logic [31:0] R2 = 32'hBBBB_0002;

   typedef struct packed {
      logic        stall;
      logic        fire;
      logic [1:0]  s1;
      logic [31:0] v1;
      logic [1:0]  s2;
      logic [31:0] v2;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   obs_t exp_q[$];
   obs_t e;
   obs_t obs;

   always #5 clk = ~clk;

   id_hazard_scoreboard_if bus ();
   id_hazard_scoreboard dut (.clk(clk), .rst(rst), .bus(bus));

   assign obs = {bus.stall, bus.id_fire, bus.rs1_sel, bus.rs1_val, bus.rs2_sel, bus.rs2_val};

   function automatic obs_t mk(input logic st, input logic fi, input logic [1:0] s1,
                               input logic [31:0] v1, input logic [1:0] s2, input logic [31:0] v2);
      return {st, fi, s1, v1, s2, v2};
   endfunction

   task automatic drive(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic wr, input logic [2:0] lat);
      bus.id_valid    = v;
      bus.id_rs1_idx  = rs1;
      bus.id_rs1_used = u1;
      bus.id_rs2_idx  = rs2;
      bus.id_rs2_used = u2;
      bus.id_rd_idx   = rd;
      bus.id_reg_wr   = wr;
      bus.id_lat      = lat;
      bus.ex_ready    = 1'b1;
      bus.flush       = 1'b0;
      bus.rf_rs1_data = R1;
      bus.rf_rs2_data = R2;
      bus.fwd_rd      = '0;
      bus.fwd_wr      = '0;
      bus.fwd_data    = '0;
   endtask

   task automatic set_fwd(input int k, input logic [4:0] rd, input logic [31:0] d);
      bus.fwd_rd[k*5 +: 5]    = rd;
      bus.fwd_wr[k]           = 1'b1;
      bus.fwd_data[k*32 +: 32] = d;
   endtask

   task automatic drain();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      exp_q.push_back(mk(0, 0, 0, R1, 0, R2));
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL reset_idle: got %h want %h", obs, e); end
      n_vec++;
      if (bus.stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", bus.stall_cnt); end
      @(posedge clk); #1;
      drive(1, 1, 1, 0, 0, 11, 1, 3);
      @(posedge clk); #1;
      rst = 1'b1;
      drive(1, 11, 1, 11, 1, 0, 0, 0);
      exp_q.push_back(mk(0, 1, 0, R1, 0, R2));
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL reset_dominates_issue: got %h want %h", obs, e); end
      @(posedge clk); #1;
   endtask

   task automatic test_load_use();
      drive(1, 2, 1, 0, 0, 5, 1, 1);
      exp_q.push_back(mk(0, 1, 0, R1, 0, R2));
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL lu_issue: got %h want %h", obs, e); end
      @(posedge clk); #1;
      drive(1, 5, 1, 1, 1, 6, 1, 0);
      exp_q.push_back(mk(1, 0, 0, R1, 0, R2));
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL lu_stall: got %h want %h", obs, e); end
      @(posedge clk); #1;
      drive(1, 5, 1, 1, 1, 6, 1, 0);
      set_fwd(1, 5, 32'h1234);
      exp_q.push_back(mk(0, 1, 2, 32'h1234, 0, R2));
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL lu_forward: got %h want %h", obs, e); end
      n_vec++;
      if (bus.stall_cnt !== 32'd1) begin n_err++; $display("FAIL lu_stall_cnt: got %0d want 1", bus.stall_cnt); end
      @(posedge clk); #1;
   endtask

   task automatic test_alu_back_to_back();
      drive(1, 1, 1, 0, 0, 3, 1, 0);
      exp_q.push_back(mk(0, 1, 0, R1, 0, R2));
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL alu_issue: got %h want %h", obs, e); end
      @(posedge clk); #1;
      drive(1, 3, 1, 3, 1, 4, 1, 0);
      set_fwd(0, 3, 32'hA);
      exp_q.push_back(mk(0, 1, 1, 32'hA, 1, 32'hA));
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL alu_forward: got %h want %h", obs, e); end
      @(posedge clk); #1;
   endtask

   task automatic test_priority();
      drive(1, 7, 1, 2, 0, 0, 0, 0);
      set_fwd(0, 7, 32'h11);
      set_fwd(2, 7, 32'h33);
      exp_q.push_back(mk(0, 1, 1, 32'h11, 0, R2));
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL prio_youngest: got %h want %h", obs, e); end
      @(posedge clk); #1;
      drive(1, 7, 1, 2, 0, 0, 0, 0);
      set_fwd(0, 7, 32'h11);
      set_fwd(2, 7, 32'h33);
      bus.fwd_wr[0] = 1'b0;
      exp_q.push_back(mk(0, 1, 3, 32'h33, 0, R2));
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL prio_oldest: got %h want %h", obs, e); end
      @(posedge clk); #1;
   endtask

   task automatic test_x0_unused();
      drive(1, 1, 1, 0, 0, 0, 1, 3);
      exp_q.push_back(mk(0, 1, 0, R1, 0, R2));
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL x0_issue: got %h want %h", obs, e); end
      @(posedge clk); #1;
      drive(1, 0, 1, 0, 1, 1, 0, 0);
      set_fwd(0, 0, 32'h55);
      exp_q.push_back(mk(0, 1, 0, R1, 0, R2));
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL x0_read: got %h want %h", obs, e); end
      @(posedge clk); #1;
      drive(1, 1, 1, 0, 0, 8, 1, 2);
      exp_q.push_back(mk(0, 1, 0, R1, 0, R2));
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL unused_issue: got %h want %h", obs, e); end
      @(posedge clk); #1;
      drive(1, 1, 1, 8, 0, 0, 0, 0);
      set_fwd(0, 8, 32'h77);
      exp_q.push_back(mk(0, 1, 0, R1, 0, R2));
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL unused_rs2: got %h want %h", obs, e); end
      @(posedge clk); #1;
   endtask

   task automatic test_multi_cycle();
      logic [1:0] st_seq [4] = '{1, 1, 1, 0};
      drive(1, 1, 1, 0, 0, 9, 1, 2);
      exp_q.push_back(mk(0, 1, 0, R1, 0, R2));
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL mul_issue: got %h want %h", obs, e); end
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         drive(1, 9, 1, 0, 0, 10, 0, 0);
         bus.ex_ready = (i != 1);
         exp_q.push_back(mk(st_seq[i][0], !st_seq[i][0], 0, R1, 0, R2));
         @(negedge clk);
         e = exp_q.pop_front(); n_vec++;
         if (obs !== e) begin n_err++; $display("FAIL mul_dep_%0d: got %h want %h", i, obs, e); end
         @(posedge clk); #1;
      end
      n_vec++;
      if (bus.stall_cnt !== 32'd4) begin n_err++; $display("FAIL mul_stall_cnt: got %0d want 4", bus.stall_cnt); end
      drive(1, 1, 1, 0, 0, 9, 1, 2);
      exp_q.push_back(mk(0, 1, 0, R1, 0, R2));
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL waw_first: got %h want %h", obs, e); end
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      drive(1, 1, 1, 0, 0, 9, 1, 2);
      exp_q.push_back(mk(0, 1, 0, R1, 0, R2));
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL waw_reissue: got %h want %h", obs, e); end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         drive(1, 9, 1, 0, 0, 0, 0, 0);
         exp_q.push_back(mk(i < 2, i == 2, 0, R1, 0, R2));
         @(negedge clk);
         e = exp_q.pop_front(); n_vec++;
         if (obs !== e) begin n_err++; $display("FAIL waw_dep_%0d: got %h want %h", i, obs, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_and_flush();
      drive(1, 1, 1, 0, 0, 5, 1, 2);
      exp_q.push_back(mk(0, 1, 0, R1, 0, R2));
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL rm_issue: got %h want %h", obs, e); end
      @(posedge clk); #1;
      drive(1, 5, 1, 0, 0, 0, 0, 0);
      rst = 1'b0;
      exp_q.push_back(mk(1, 0, 0, R1, 0, R2));
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL rm_stall_before: got %h want %h", obs, e); end
      @(posedge clk); #1;
      rst = 1'b1;
      drive(1, 5, 1, 0, 0, 0, 0, 0);
      exp_q.push_back(mk(0, 1, 0, R1, 0, R2));
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL rm_after: got %h want %h", obs, e); end
      n_vec++;
      if (bus.stall_cnt !== 32'd0) begin n_err++; $display("FAIL rm_stall_cnt: got %0d want 0", bus.stall_cnt); end
      @(posedge clk); #1;
      drive(1, 1, 1, 0, 0, 5, 1, 2);
      exp_q.push_back(mk(0, 1, 0, R1, 0, R2));
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL fl_issue: got %h want %h", obs, e); end
      @(posedge clk); #1;
      drive(1, 5, 1, 0, 0, 0, 0, 0);
      bus.flush = 1'b1;
      exp_q.push_back(mk(0, 0, 0, R1, 0, R2));
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL fl_flush: got %h want %h", obs, e); end
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         drive(1, 5, 1, 0, 0, 0, 0, 0);
         exp_q.push_back(mk(i == 0, i == 1, 0, R1, 0, R2));
         @(negedge clk);
         e = exp_q.pop_front(); n_vec++;
         if (obs !== e) begin n_err++; $display("FAIL fl_after_%0d: got %h want %h", i, obs, e); end
         @(posedge clk); #1;
      end
      n_vec++;
      if (bus.stall_cnt !== 32'd1) begin n_err++; $display("FAIL fl_stall_cnt: got %0d want 1", bus.stall_cnt); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_alu_back_to_back();
      test_priority();
      test_x0_unused();
      drain();
      test_multi_cycle();
      drain();
      test_reset_mid_and_flush();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
- Parametrised successor to the decode-stage hazard/forwarding logic.
- Tracks per-register result-availability countdowns so that multi-cycle producers (load, multiply, future long ops) raise stalls automatically.
- Selects operand bypass from N ordered forward sources and counts stall cycles.
- Sits in ID, between the regfile read ports and the ID/EX register.

Parameters:
- NUM_REGS, 32, architectural register count; index 0 hard-wired zero.
- IDX_W, 5, register index width (= clog2(NUM_REGS)).
- XLEN, 32, data width.
- NUM_FWD, 3, number of forward sources; index 0 is youngest (EX), ascending is older (MEM, WB).
- LAT_W, 3, countdown width; max producer latency is 2^LAT_W-1.
- SEL_W, 2, operand-select width (= clog2(NUM_FWD+1)).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1_idx, id_rs2_idx  in  IDX_W each  source indices.
- id_rs1_used, id_rs2_used  in  1 each  source actually read by the instruction.
- id_rd_idx  in  IDX_W  destination index.
- id_reg_wr  in  1  instruction writes rd.
- id_lat  in  LAT_W  cycles after issue before result appears on a forward source (ALU 0, load 1, mul 2).
- ex_ready  in  1  downstream pipeline advances this cycle.
- flush  in  1  squash the ID instruction (branch taken).
- rf_rs1_data, rf_rs2_data  in  XLEN each  regfile read data.
- fwd_rd  in  NUM_FWD*IDX_W  packed source destination indices.
- fwd_wr  in  NUM_FWD  packed source write-enables (valid & reg_wr).
- fwd_data  in  NUM_FWD*XLEN  packed source results.
- rs1_val, rs2_val  out  XLEN each  resolved operand values.
- rs1_sel, rs2_sel  out  SEL_W each  0 = regfile; k+1 = fwd source k.
- stall  out  1  hold PC and IF/ID; inject bubble into ID/EX.
- id_fire  out  1  instruction issues into ID/EX this cycle.
- stall_cnt  out  32  saturating count of cycles with stall=1.

Behaviour:
- State: cnt[r] (LAT_W bits) for r = 1..NUM_REGS-1; cnt[0] is constant 0; stall_cnt.
- Reset (rst=0 at a clk edge): all cnt=0 and stall_cnt=0. Reset dominates any simultaneous issue.
- Stall is combinational: stall = id_valid & ~flush & (hazA | hazB), where hazA = id_rs1_used & (id_rs1_idx!=0) & (cnt[id_rs1_idx]!=0). hazB is the same for rs2.
- Issue: id_fire = id_valid & ~stall & ~flush & ex_ready.
- Counter update, only when ex_ready=1:
  - If id_fire & id_reg_wr & id_rd_idx!=0, then cnt[id_rd_idx] <= id_lat.
  - Every other nonzero cnt decrements by 1.
  - Issue overrides the decrement on the same register, so a WAW re-issue reloads the count.
- When ex_ready=0, all cnt hold.
- id_lat=0 leaves cnt at 0; no stall arises and forwarding covers the dependency.
- Forward select, per operand:
  - If the index is 0, or the operand is unused, sel=0.
  - Otherwise pick the lowest k with fwd_wr[k] & fwd_rd[k]==idx, and set sel=k+1. Youngest wins.
  - With no match, sel=0.
  - val is muxed accordingly, purely combinational, with no latency.
- While stall=1, sel/val still reflect current matches. ID/EX must treat them as don't-care (bubble).
- stall_cnt increments on each edge where stall=1 and rst=1, and saturates at 0xFFFFFFFF.
- flush=1 forces stall=0 and id_fire=0. Counters still decrement if ex_ready=1. Older in-flight producers are unaffected.
- Simultaneous case: a decode reading register r while an issue into r happens reads the old cnt[r]. Hazard detection is against older instructions only.

Test Plan:
- Load-use:
  - Stimulus: issue lw x5 (id_lat=1), then next cycle add x6,x5,x1.
  - Required: stall=1 for exactly 1 cycle and stall_cnt=1.
  - Required: on the following cycle, with fwd_rd[1]=5, fwd_wr[1]=1, fwd_data[1]=0x1234, expect rs1_sel=2 and rs1_val=0x1234.
- ALU back-to-back:
  - Stimulus: issue addi x3 (lat 0), then add x4,x3,x3 with fwd_rd[0]=3, fwd_data[0]=0xA.
  - Required: stall=0, rs1_sel=rs2_sel=1, both vals 0xA.
- Priority:
  - Stimulus: fwd_rd[0]=fwd_rd[2]=7, both fwd_wr set, data 0x11 and 0x33.
  - Required: rs1_sel=1, rs1_val=0x11. With fwd_wr[0]=0, expect sel=3 and val 0x33.
- x0 and unused operands:
  - Stimulus: cnt targeted at x0 via an issue to rd=0 with lat 3, then a read of x0; separately, rs2_used=0 with cnt[rs2]=2.
  - Required: no stall in either case, and sel=0.
- Multi-cycle plus ex_ready:
  - Stimulus: mul x9 (lat 2), dependent instruction next, with ex_ready=0 for 1 cycle inside the window.
  - Required: stall lasts 3 cycles. Re-issuing to x9 with lat 2 while cnt[x9]=1 reloads cnt to 2.
- Reset mid-operation:
  - Stimulus: cnt[x5]=2 with stall asserted, then rst=0 for one edge.
  - Required: next cycle all cnt=0, stall=0, stall_cnt=0.
  - Required: flush=1 with a pending hazard gives stall=0 and id_fire=0.
